// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way source-select mux family.
// - clog2 : ceiling log2, used to derive the select width from N
// - W_DEF / N_DEF / CNT_W_DEF : default data width, channel count, error counter width
// - `MUX_LANE(bus, k, w) : extract lane k (w bits wide) from a flattened bus
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

`define MUX_LANE(bus, k, w) bus[(k)*(w) +: (w)]

package mux_pkg;

  localparam int W_DEF     = 16;
  localparam int N_DEF     = 5;
  localparam int CNT_W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one skid register.
// in_ready comes straight from the skid-full flop, so there is no combinational
// path from out_ready back upstream while full throughput is still sustained.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_push, in_data    word to store (caller only pushes while in_ready=1)
//   in_ready            skid register empty
//   out_data, out_valid head of the FIFO, held stable until delivered
//   out_ready           downstream accepts this cycle
module mux_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_push,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, skid_q;
  logic         out_v, skid_v;
  logic         deliver;

  assign deliver   = out_v & out_ready;
  assign in_ready  = ~skid_v;
  assign out_data  = out_q;
  assign out_valid = out_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      // Full: nothing can be pushed; the skid word refills out as it drains.
      if (deliver) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (in_push) begin
      if (!out_v || deliver) begin
        out_q <= in_data;
        out_v <= 1'b1;
      end else begin
        skid_q <= in_data;
        skid_v <= 1'b1;
      end
    end else if (deliver) begin
      out_v <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way, W-bit source-select mux with valid/ready handshake.
// The selected lane appears on out one edge after acceptance; out-of-range
// selects are consumed without producing a word and are logged in err/err_count.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   in_bus [N*W]         lane k at in_bus[k*W +: W]
//   set [SW]             lane select, sampled with in_valid
//   in_valid / in_ready  upstream handshake
//   out / out_valid      selected word, registered
//   out_ready            downstream handshake
//   err                  sticky bad-select flag
//   err_count [CNT_W]    saturating bad-select count
//   err_clr              synchronous clear of err and err_count
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int N     = N_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int SW    = clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*W-1:0]   in_bus,
  input  logic [SW-1:0]    set,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  logic         accept;
  logic         sel_ok;
  logic         bad_acc;
  logic [W-1:0] sel_word;

  // Lane decode. Each lane index is compared against the select, so the
  // part-select base is a constant; anything not matching a lane falls
  // through to the zero default (set >= N), which also keeps this latch-free.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (set == SW'(k)) begin
        sel_word = `MUX_LANE(in_bus, k, W);
        sel_ok   = 1'b1;
      end
    end
  end

  assign accept  = in_valid & in_ready;
  assign bad_acc = accept & ~sel_ok;

  mux_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .in_push   (accept & sel_ok),
    .in_data   (sel_word),
    .in_ready  (in_ready),
    .out_data  (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // A bad accept beats a same-cycle clear: the count restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (bad_acc) begin
      err <= 1'b1;
      if (err_clr)
        err_count <= CNT_W'(1);
      else if (!(&err_count))
        err_count <= err_count + CNT_W'(1);
    end else if (err_clr) begin
      err       <= 1'b0;
      err_count <= '0;
    end
  end

endmodule
